vmem_sequencer: RTL
===================

VMEM_SEQUENCER -- requirements
Module: vmem_sequencer

Interface
REQ-001 Parameter NELEM, default 8: maximum elements per vector operation (VLEN/SEW).
REQ-002 Parameter EW, default 32: element and address width in bits.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request to begin a vector memory operation; operands are valid in the same cycle.
REQ-006 IsStore  input  1  1 = store (VSE/VSSE/VSUXEI), 0 = load (VLE/VLSE/VLUXEI).
REQ-007 Mode  input  2  00 unit-stride, 01 strided, 10 indexed-unordered, 11 reserved.
REQ-008 Base  input  EW  scalar base address (rs1).
REQ-009 Stride  input  EW  byte stride (rs2), used in strided mode only.
REQ-010 VL  input  4  active element count.
REQ-011 VIdx  input  NELEM*EW  index vector; element i is at bits [i*EW +: EW].
REQ-012 VStData  input  NELEM*EW  store data vector, same packing.
REQ-013 MemReq, MemWe  output  1 each  memory request valid; write qualifier.
REQ-014 MemAddr, MemWData  output  EW each  request address; store data.
REQ-015 MemAck  input  1  memory accepts the request this cycle; for loads MemRData is valid in the same cycle.
REQ-016 MemRData  input  EW  load return data.
REQ-017 VLdData  output  NELEM*EW  assembled load vector.
REQ-018 VLdEn  output  NELEM  per-element VRF write enable.
REQ-019 Busy, Done, Err  output  1 each  operation in progress; one-cycle completion pulse; error flag, valid with Done.

Function
REQ-020 FSM states: IDLE, ISSUE, DONE.
REQ-021 IDLE: Start latches IsStore, Mode, Base, Stride, VL, VIdx and VStData, clears the element counter, and goes to ISSUE; if VL==0, it goes straight to DONE.
REQ-022 Start is ignored while Busy=1; Busy=1 in ISSUE and DONE.
REQ-023 VL>NELEM is clamped to NELEM at latch time.
REQ-024 ISSUE: MemReq=1, MemWe=IsStore, MemWData=element i of VStData.
REQ-025 MemAddr, element i: unit-stride Base+i*(EW/8); strided Base+i*Stride; indexed Base+VIdx[i]; mode 11 behaves as unit-stride.
REQ-026 All address arithmetic is modulo 2^EW with no overflow flag; MemAddr and MemReq stay stable until MemAck.
REQ-027 On MemAck in ISSUE: a load writes MemRData into VLdData element i; i increments; when i+1==VL the FSM goes to DONE.
REQ-028 DONE (exactly one cycle): Done=1; VLdEn bits [VL-1:0]=1 for loads, all 0 for stores; Busy=1; next state IDLE.
REQ-029 With MemAck held at 1, Start at cycle 0 gives MemReq in cycles 1..VL and Done in cycle VL+1.
REQ-030 VLdData holds its value until the next load's first MemAck; elements >= VL keep their prior values.
REQ-031 A Start arriving in the DONE cycle is ignored.

Reset
REQ-032 Rst asserted: state=IDLE, counter=0, VLdData=0, and MemReq, MemWe, Done, Err, Busy, VLdEn all =0, taking effect immediately without waiting for Clk.
REQ-033 Rst mid-operation abandons the operation with no Done pulse; an outstanding MemReq drops asynchronously.

Configuration
REQ-034 Macro VMEM_MISALIGN_CHECK_EN defined: in ISSUE, if MemAddr[1:0]!=0, MemReq stays 0 for that element, the FSM goes to DONE with Err=1, and VLdEn covers only completed elements (bits [i-1:0]).
REQ-035 Macro undefined: Err is constant 0 and misaligned addresses are issued unchanged.

Verification
REQ-036 Unit-stride load: Base=0x1000, VL=4, MemAck=1 -> MemAddr 0x1000, 0x1004, 0x1008, 0x100C in cycles 1-4; Done in cycle 5; VLdEn=0x0F.
REQ-037 Strided store: Base=0x2000, Stride=0xFFFFFFF0, VL=3, VStData elements {A,B,C} -> addresses 0x2000, 0x1FF0, 0x1FE0; MemWe=1; MemWData A, B, C; VLdEn=0.
REQ-038 Indexed load with MemAck delayed 2 cycles per element: Base=0x100, VIdx={8,0,4}, VL=3 -> addresses 0x108, 0x100, 0x104, each held stable until ack; Done in cycle 10.
REQ-039 VL=0 and VL=12: VL=0 gives Done in cycle 1 with no MemReq; VL=12 issues 8 requests.
REQ-040 Rst after element 2 of an 8-element load -> MemReq=0 at once, no Done, VLdData=0; the next Start operates normally.
REQ-041 With VMEM_MISALIGN_CHECK_EN: unit-stride Base=0x1002 -> no MemReq, Done with Err=1, VLdEn=0.

Source files
------------

// File: rtl/vmem_sequencer.sv
// Vector memory sequencer: walks unit-stride, strided or indexed element addresses and
// gathers load data or scatters store data. Optional misalignment trap: VMEM_MISALIGN_CHECK_EN.
module vmem_sequencer #(
  parameter int NELEM = 8,
  parameter int EW    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  is_store_i,
  input  logic [1:0]            mode_i,
  input  logic [EW-1:0]         base_i,
  input  logic [EW-1:0]         stride_i,
  input  logic [3:0]            vl_i,
  input  logic [NELEM*EW-1:0]   vidx_i,
  input  logic [NELEM*EW-1:0]   vst_data_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [EW-1:0]         mem_addr_o,
  output logic [EW-1:0]         mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [EW-1:0]         mem_rdata_i,
  output logic [NELEM*EW-1:0]   vld_data_o,
  output logic [NELEM-1:0]      vld_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int IW = (NELEM > 1) ? $clog2(NELEM) : 1;

  // S_IDLE  | waiting for start_i
  // S_ISSUE | one memory request per element until the last ack
  // S_DONE  | single-cycle completion pulse, load write enables
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          store_q, store_d;
  logic [1:0]    mode_q, mode_d;
  logic [EW-1:0] base_q, base_d;
  logic [EW-1:0] stride_q, stride_d;
  logic [3:0]    vl_q, vl_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [EW-1:0] vidx_q [NELEM];
  logic [EW-1:0] vidx_d [NELEM];
  logic [EW-1:0] vst_q  [NELEM];
  logic [EW-1:0] vst_d  [NELEM];
  logic [EW-1:0] vld_q  [NELEM];
  logic [EW-1:0] vld_d  [NELEM];

  logic [IW-1:0] elem;
  logic [EW-1:0] offs;
  logic [EW-1:0] addr;
  logic [3:0]    vl_clamp;
  logic [3:0]    cnt_inc;
  logic          misalign;

  assign elem     = cnt_q[IW-1:0];
  assign cnt_inc  = cnt_q + 4'd1;
  assign vl_clamp = (int'(vl_i) > NELEM) ? 4'(NELEM) : vl_i;

  // Offsets wrap modulo 2^EW; a negative stride is just a large unsigned value.
  always_comb begin
    offs = EW'(cnt_q) * EW'(EW / 8);
    case (mode_q)
      2'b01:   offs = EW'(cnt_q) * stride_q;
      2'b10:   offs = vidx_q[elem];
      default: offs = EW'(cnt_q) * EW'(EW / 8);
    endcase
    addr = base_q + offs;
  end

  assign mem_addr_o  = addr;
  assign mem_wdata_o = vst_q[elem];

`ifdef VMEM_MISALIGN_CHECK_EN
  logic err_q;

  assign misalign = (addr[1:0] != 2'b00);
  assign err_o    = (state_q == S_DONE) && err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (state_q == S_IDLE && start_i)
      err_q <= 1'b0;
    else if (state_q == S_ISSUE && misalign)
      err_q <= 1'b1;
  end
`else
  assign misalign = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    mode_d    = mode_q;
    base_d    = base_q;
    stride_d  = stride_q;
    vl_d      = vl_q;
    cnt_d     = cnt_q;
    vidx_d    = vidx_q;
    vst_d     = vst_q;
    vld_d     = vld_q;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    done_o    = 1'b0;
    vld_en_o  = '0;
    busy_o    = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          store_d  = is_store_i;
          mode_d   = mode_i;
          base_d   = base_i;
          stride_d = stride_i;
          vl_d     = vl_clamp;
          cnt_d    = 4'd0;
          for (int k = 0; k < NELEM; k++) begin
            vidx_d[k] = vidx_i[k*EW +: EW];
            vst_d[k]  = vst_data_i[k*EW +: EW];
          end
          state_d = (vl_clamp == 4'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (misalign) begin
          state_d = S_DONE;
        end else begin
          mem_req_o = 1'b1;
          mem_we_o  = store_q;
          if (mem_ack_i) begin
            if (!store_q) vld_d[elem] = mem_rdata_i;
            cnt_d = cnt_inc;
            if (cnt_inc == vl_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        // cnt_q counts completed elements, so this also covers an early misalign exit.
        if (!store_q)
          for (int k = 0; k < NELEM; k++) vld_en_o[k] = (k < int'(cnt_q));
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_data_o = '0;
    for (int k = 0; k < NELEM; k++) vld_data_o[k*EW +: EW] = vld_q[k];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      mode_q   <= 2'b00;
      base_q   <= '0;
      stride_q <= '0;
      vl_q     <= 4'd0;
      cnt_q    <= 4'd0;
      vidx_q   <= '{default: '0};
      vst_q    <= '{default: '0};
      vld_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      vl_q     <= vl_d;
      cnt_q    <= cnt_d;
      vidx_q   <= vidx_d;
      vst_q    <= vst_d;
      vld_q    <= vld_d;
    end
  end

endmodule
